// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: a RESET/EXEC/HALT state plus a step counter (T0..T7).
// Each strobe is decoded from the registered state and the opcode field of IR.
module control_sequencer #(
   parameter int OPW      = 5,
   parameter int MAX_STEP = 7
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        BranchOut,
   input  logic        Stop,
   output logic        Run,
   output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Rout, BAout, Cout, InPortout,
   output logic        PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn,
   output logic        Gra, Grb, Grc,
   output logic        Read, Write,
   output logic        IncPC, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
);
   localparam int SW = $clog2(MAX_STEP + 1);
   localparam logic [SW-1:0] T0 = SW'(0), T1 = SW'(1), T2 = SW'(2), T3 = SW'(3);
   localparam logic [SW-1:0] T4 = SW'(4), T5 = SW'(5), T6 = SW'(6), T7 = SW'(7);

   localparam logic [OPW-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100;
   localparam logic [OPW-1:0] OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
   localparam logic [OPW-1:0] OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_HALT = 5'b11011;

   typedef enum logic [1:0] {RESET, EXEC, HALT} state_t;

   state_t         state;
   logic [SW-1:0]  step;
   logic           taken;
   logic [OPW-1:0] opcode;
   logic [SW-1:0]  last_step;
   logic           alu_en;
   logic           unused_ir_bits;

   assign opcode         = IR[31 -: OPW];
   assign unused_ir_bits = ^IR[31-OPW:0];

   always_comb begin
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
         OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:          last_step = T5;
         OP_NEG, OP_NOT, OP_JAL:                    last_step = T4;
         OP_MUL, OP_DIV, OP_ST, OP_BR:              last_step = T6;
         OP_LD:                                     last_step = SW'(MAX_STEP);
         OP_JR, OP_IN, OP_OUT, OP_MFLO, OP_MFHI:    last_step = T3;
         default:                                   last_step = T2;
      endcase
   end

   // The opcode on IR must already be the fetched instruction when leaving T2;
   // the branch condition is captured on entry to T6 so strobes only move on edges.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state <= RESET;
         step  <= T0;
         taken <= 1'b0;
      end else begin
         case (state)
            RESET: begin
               state <= EXEC;
               step  <= T0;
            end
            EXEC: begin
               if (step == T2 && (Stop || opcode == OP_HALT))
                  state <= HALT;
               else if (step == last_step)
                  step <= T0;
               else
                  step <= step + 1'b1;
               if (step == T5)
                  taken <= BranchOut;
            end
            default: state <= HALT;
         endcase
      end
   end

   always_comb begin
      {PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Rout, BAout, Cout, InPortout} = '0;
      {PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn} = '0;
      {Gra, Grb, Grc, Read, Write} = '0;
      {IncPC, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT} = '0;
      alu_en = 1'b0;
      Run    = (state == EXEC);
      if (state == EXEC) begin
         case (step)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            default: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                  OP_ADDI, OP_ANDI, OP_ORI: begin
                     if (step == T3) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                     if (step == T4) begin
                        alu_en = 1'b1; Zin = 1'b1;
                        if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI)
                           Cout = 1'b1;
                        else begin
                           Grc = 1'b1; Rout = 1'b1;
                        end
                     end
                     if (step == T5) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  end
                  OP_NEG, OP_NOT: begin
                     if (step == T3) begin Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
                     if (step == T4) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  end
                  OP_MUL, OP_DIV: begin
                     if (step == T3) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                     if (step == T4) begin Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
                     if (step == T5) begin Zlowout = 1'b1; LOin = 1'b1; end
                     if (step == T6) begin Zhighout = 1'b1; HIin = 1'b1; end
                  end
                  OP_LD, OP_LDI, OP_ST: begin
                     if (step == T3) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                     if (step == T4) begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                     if (step == T5) begin
                        Zlowout = 1'b1;
                        if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                        else MARin = 1'b1;
                     end
                     if (step == T6 && opcode == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
                     if (step == T6 && opcode == OP_ST) begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
                     if (step == T7 && opcode == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  end
                  OP_BR: begin
                     if (step == T3) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                     if (step == T4) begin PCout = 1'b1; Yin = 1'b1; end
                     if (step == T5) begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                     if (step == T6 && taken) begin Zlowout = 1'b1; PCin = 1'b1; end
                  end
                  OP_JR:   if (step == T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  OP_JAL: begin
                     if (step == T3) begin PCout = 1'b1; RAin = 1'b1; end
                     if (step == T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  end
                  OP_IN:   if (step == T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_OUT:  if (step == T3) begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                  OP_MFLO: if (step == T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MFHI: if (step == T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
               endcase
            end
         endcase
      end
      if (alu_en) begin
         case (opcode)
            OP_ADD, OP_ADDI: ADD  = 1'b1;
            OP_SUB:          SUB  = 1'b1;
            OP_AND, OP_ANDI: AND  = 1'b1;
            OP_OR, OP_ORI:   OR   = 1'b1;
            OP_ROR:          ROR  = 1'b1;
            OP_ROL:          ROL  = 1'b1;
            OP_SHR:          SHR  = 1'b1;
            OP_SHRA:         SHRA = 1'b1;
            OP_SHL:          SHL  = 1'b1;
            OP_MUL:          MUL  = 1'b1;
            OP_DIV:          DIV  = 1'b1;
            OP_NEG:          NEG  = 1'b1;
            OP_NOT:          NOT  = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a text microprogram model checked every cycle,
// plus directed instruction sequences with hand-computed strobe expectations.
module tb_control_sequencer;
   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic [31:0] IR;
   logic        BranchOut, Stop;
   logic        Run;
   logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Rout, BAout, Cout, InPortout;
   logic        PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn;
   logic        Gra, Grb, Grc, Read, Write;
   logic        IncPC, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT;
   logic [41:0] vec;

   control_sequencer #(.OPW(5), .MAX_STEP(7)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut), .Stop(Stop), .Run(Run),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .LOout(LOout),
      .HIout(HIout), .Rout(Rout), .BAout(BAout), .Cout(Cout), .InPortout(InPortout),
      .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
      .LOin(LOin), .HIin(HIin), .Rin(Rin), .RAin(RAin), .CONin(CONin), .OutPortIn(OutPortIn),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
      .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA),
      .SHL(SHL), .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT)
   );

   always #5 Clock = ~Clock;

   // Bit i of vec is the signal named names[i]; bits 1..10 are the bus drives.
   assign vec = {NOT, NEG, OR, AND, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, IncPC,
                 Write, Read, Grc, Grb, Gra, OutPortIn, CONin, RAin, Rin, HIin, LOin, MDRin,
                 MARin, Zin, Yin, IRin, PCin, InPortout, Cout, BAout, Rout, HIout, LOout,
                 MDRout, Zhighout, Zlowout, PCout, Run};

   string names [42] = '{"Run", "PCout", "Zlowout", "Zhighout", "MDRout", "LOout", "HIout",
      "Rout", "BAout", "Cout", "InPortout", "PCin", "IRin", "Yin", "Zin", "MARin", "MDRin",
      "LOin", "HIin", "Rin", "RAin", "CONin", "OutPortIn", "Gra", "Grb", "Grc", "Read",
      "Write", "IncPC", "ADD", "SUB", "MUL", "DIV", "SHR", "SHRA", "SHL", "ROR", "ROL",
      "AND", "OR", "NEG", "NOT"};

   int errors = 0;
   int checks = 0;
   int m_mode;           // 0 reset, 1 running, 2 halted
   int m_pos;            // current micro-step number
   logic m_taken;

   function automatic string alu_name(logic [4:0] op);
      case (op)
         5'b00011, 5'b01100: return "ADD";
         5'b00100:           return "SUB";
         5'b00101, 5'b01101: return "AND";
         5'b00110, 5'b01110: return "OR";
         5'b00111:           return "ROR";
         5'b01000:           return "ROL";
         5'b01001:           return "SHR";
         5'b01010:           return "SHRA";
         5'b01011:           return "SHL";
         5'b10000:           return "MUL";
         5'b01111:           return "DIV";
         5'b10001:           return "NEG";
         5'b10010:           return "NOT";
         default:            return "";
      endcase
   endfunction

   // Execute microprogram: k=0 is T3. "END" marks past the last step, "BR" the conditional step.
   function automatic string exec_step(logic [4:0] op, int k);
      string a;
      string s;
      a = alu_name(op);
      s = "END";
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
            if (k == 0) s = "Grb Rout Yin";
            else if (k == 1) s = {"Grc Rout ", a, " Zin"};
            else if (k == 2) s = "Zlowout Gra Rin";
         end
         5'b01100, 5'b01101, 5'b01110: begin
            if (k == 0) s = "Grb Rout Yin";
            else if (k == 1) s = {"Cout ", a, " Zin"};
            else if (k == 2) s = "Zlowout Gra Rin";
         end
         5'b10001, 5'b10010: begin
            if (k == 0) s = {"Grb Rout ", a, " Zin"};
            else if (k == 1) s = "Zlowout Gra Rin";
         end
         5'b10000, 5'b01111: begin
            if (k == 0) s = "Gra Rout Yin";
            else if (k == 1) s = {"Grb Rout ", a, " Zin"};
            else if (k == 2) s = "Zlowout LOin";
            else if (k == 3) s = "Zhighout HIin";
         end
         5'b00000, 5'b00001, 5'b00010: begin
            if (k == 0) s = "Grb BAout Yin";
            else if (k == 1) s = "Cout ADD Zin";
            else if (k == 2 && op == 5'b00001) s = "Zlowout Gra Rin";
            else if (k == 2) s = "Zlowout MARin";
            else if (k == 3 && op == 5'b00000) s = "Read MDRin";
            else if (k == 3 && op == 5'b00010) s = "Gra Rout Write";
            else if (k == 4 && op == 5'b00000) s = "MDRout Gra Rin";
         end
         5'b10011: begin
            if (k == 0) s = "Gra Rout CONin";
            else if (k == 1) s = "PCout Yin";
            else if (k == 2) s = "Cout ADD Zin";
            else if (k == 3) s = "BR";
         end
         5'b10101: if (k == 0) s = "Gra Rout PCin";
         5'b10100: begin
            if (k == 0) s = "PCout RAin";
            else if (k == 1) s = "Gra Rout PCin";
         end
         5'b10110: if (k == 0) s = "InPortout Gra Rin";
         5'b10111: if (k == 0) s = "Gra Rout OutPortIn";
         5'b11000: if (k == 0) s = "LOout Gra Rin";
         5'b11001: if (k == 0) s = "HIout Gra Rin";
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic [41:0] mask_of(string s);
      logic [41:0] m;
      string tok;
      bit found;
      m = '0;
      tok = "";
      for (int i = 0; i <= s.len(); i++) begin
         if (i == s.len() || s.substr(i, i) == " ") begin
            if (tok.len() > 0) begin
               found = 0;
               for (int b = 0; b < 42; b++)
                  if (names[b] == tok) begin m[b] = 1'b1; found = 1; end
               if (!found) $display("model: unknown signal name %s", tok);
            end
            tok = "";
         end else
            tok = {tok, s.substr(i, i)};
      end
      return m;
   endfunction

   function automatic logic [41:0] model_exp();
      string s;
      if (m_mode != 1) return '0;
      if (m_pos == 0) s = "PCout MARin IncPC Zin";
      else if (m_pos == 1) s = "Zlowout PCin Read MDRin";
      else if (m_pos == 2) s = "MDRout IRin";
      else s = exec_step(IR[31:27], m_pos - 3);
      if (s == "BR") s = m_taken ? "Zlowout PCin" : "";
      return mask_of(s) | 42'd1;
   endfunction

   // Instruction-level model advanced on each clock or clear.
   initial begin
      m_mode = 0; m_pos = 0; m_taken = 1'b0;
      forever begin
         @(posedge Clock or posedge Clear);
         if (Clear) m_mode = 0;
         else if (m_mode == 0) begin m_mode = 1; m_pos = 0; end
         else if (m_mode == 1) begin
            if (m_pos == 2 && (Stop || IR[31:27] == 5'b11011)) m_mode = 2;
            else if (m_pos >= 2 && exec_step(IR[31:27], m_pos - 2) == "END") m_pos = 0;
            else begin
               m_pos++;
               if (m_pos == 6) m_taken = BranchOut;
            end
         end
      end
   end

   initial begin
      logic [41:0] exp;
      forever begin
         @(negedge Clock);
         exp = model_exp();
         checks++;
         if (vec !== exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t mode=%0d pos=%0d got=%h want=%h", $time, m_mode, m_pos, vec, exp);
         end
         checks++;
         assert ($onehot0(vec[10:1])) else begin
            errors++;
            $display("FAIL bus_onehot t=%0t got=%b want at most one bus drive", $time, vec[10:1]);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end else
         $display("ok   %s t=%0t value=%h", name, $time, act);
   endtask

   task automatic set_op(logic [4:0] op);
      IR = {op, 27'($urandom)};
   endtask

   task automatic chk_t0(string name);
      chk(name, {PCout, MARin, IncPC, Zin, Run}, 5'b11111);
   endtask

   int lens [32] = '{8, 6, 7, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 7,
                     7, 5, 5, 7, 5, 4, 4, 4, 4, 4, 3, 0, 3, 3, 3, 3};

   initial begin
      int n;
      IR = '0; BranchOut = 1'b0; Stop = 1'b0;
      tick();
      chk("reset_outputs", vec, 0);
      Clear = 1'b0;
      tick();
      chk_t0("first_t0");
      chk("first_t0_count", $countones(vec), 5);

      set_op(5'b00011);
      ticks(3);
      chk("add_t3", {Grb, Rout, Yin, Run}, 4'hF);
      chk("add_t3_count", $countones(vec), 4);
      tick();
      chk("add_t4", {Grc, Rout, ADD, Zin, Run}, 5'h1F);
      chk("add_t4_count", $countones(vec), 5);
      tick();
      chk("add_t5", {Zlowout, Gra, Rin, Run}, 4'hF);
      tick();
      chk_t0("add_t0_after_6");

      set_op(5'b00011);
      ticks(4);
      Clear = 1'b1;
      #1;
      chk("clear_async_outputs", vec, 0);
      chk("clear_async_run", Run, 0);
      tick();
      Clear = 1'b0;
      tick();
      chk_t0("clear_recover_t0");

      set_op(5'b00000);
      tick();
      chk("ld_t1", {Read, MDRin}, 2'b11);
      ticks(5);
      chk("ld_t6", {Read, MDRin}, 2'b11);
      tick();
      chk("ld_t7", {MDRout, Gra, Rin}, 3'b111);
      tick();
      chk_t0("ld_t0_after_8");

      for (int b = 0; b < 2; b++) begin
         set_op(5'b10011);
         BranchOut = b[0];
         ticks(6);
         chk(b == 0 ? "br_nt_t6_pcin" : "br_tk_t6_pcin", {PCin, Zlowout}, b == 0 ? 2'b00 : 2'b11);
         tick();
         chk_t0(b == 0 ? "br_nt_t0" : "br_tk_t0");
      end
      BranchOut = 1'b0;

      set_op(5'b10000);
      ticks(5);
      chk("mul_t5", {Zlowout, LOin}, 2'b11);
      tick();
      chk("mul_t6", {Zhighout, HIin, LOin}, 3'b110);
      tick();
      set_op(5'b11001);
      ticks(3);
      chk("mfhi_t3", {HIout, Gra, Rin, Rout}, 4'b1110);
      tick();
      chk_t0("mfhi_t0");

      for (int op = 0; op < 32; op++) begin
         if (op == 27) continue;
         set_op(5'(op));
         BranchOut = 1'($urandom_range(0, 1));
         n = 0;
         do begin
            tick();
            n++;
         end while (!(PCout && IncPC && Run) && n < 20);
         chk($sformatf("length_op%0d", op), n, lens[op]);
      end

      set_op(5'b00011);
      tick();
      Stop = 1'b1;
      ticks(2);
      chk("stop_halt_outputs", vec, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Run !== 1'b0 || vec !== 0) n++;
      end
      chk("stop_halt_held_20", n, 0);
      Clear = 1'b1;
      tick();
      Stop = 1'b0;
      Clear = 1'b0;
      tick();
      chk_t0("post_halt_t0");
      set_op(5'b11011);
      ticks(3);
      chk("halt_op_run", Run, 0);
      ticks(3);
      chk("halt_op_held", vec, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
